// File: rtl/clkmux4_switch_ctrl_pkg.sv
// Shared definitions for the 4-input clock-mux switch controller.
package clkmux4_switch_ctrl_pkg;

    localparam int unsigned SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OFF_HOLD = 2'd1,
        SEL_HOLD = 2'd2,
        APPLY    = 2'd3
    } state_t;

endpackage

// File: rtl/clkmux4_switch_ctrl_wait_cnt.sv
// Loadable down-counter with enable and zero flag; saturates at zero.
module clkctrl_wait_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/clkmux4_switch_ctrl.sv
// Sequences select/enable changes for the glitch-free 4-input clock mux:
// disable, wait, change select, wait, re-enable, then pulse DONE_O.
module clkmux4_switch_ctrl
    import clkmux4_switch_ctrl_pkg::*;
#(
    parameter int unsigned OFF_WAIT = 16,
    parameter int unsigned SEL_WAIT = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             REQ_I,
    input  logic [SEL_W-1:0] REQ_SEL_I,
    input  logic             REQ_EN_I,
    output logic             READY_O,
    output logic [SEL_W-1:0] SEL_O,
    output logic             EN_O,
    output logic             DONE_O,
    output logic             BUSY_O
);

    state_t             state, state_nx;
    logic [SEL_W-1:0]   sel_q, lat_sel;
    logic               en_q, lat_en;
    logic               accept, sel_change;
    logic               cnt_load, cnt_zero, cnt_en;
    logic [CNT_W-1:0]   cnt_val;

    assign accept     = REQ_I && (state == IDLE);
    assign sel_change = (REQ_SEL_I != sel_q);
    assign cnt_en     = (state == OFF_HOLD) || (state == SEL_HOLD);

    clkctrl_wait_cnt #(.CNT_W(CNT_W)) u_wait_cnt (
        .clk      (CLK_I),
        .rst      (RST_I),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nx = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            IDLE: begin
                if (REQ_I) begin
                    if (sel_change) begin
                        state_nx = OFF_HOLD;
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(OFF_WAIT - 1);
                    end else begin
                        state_nx = APPLY;
                    end
                end
            end
            OFF_HOLD: begin
                if (cnt_zero) begin
                    state_nx = SEL_HOLD;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(SEL_WAIT - 1);
                end
            end
            SEL_HOLD: begin
                if (cnt_zero) begin
                    state_nx = APPLY;
                end
            end
            APPLY: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state   <= IDLE;
            sel_q   <= '0;
            en_q    <= 1'b0;
            lat_sel <= '0;
            lat_en  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                lat_sel <= REQ_SEL_I;
                lat_en  <= REQ_EN_I;
                if (sel_change) begin
                    en_q <= 1'b0;
                end
            end
            if ((state == OFF_HOLD) && cnt_zero) begin
                sel_q <= lat_sel;
            end
            if (state == APPLY) begin
                en_q <= lat_en;
            end
        end
    end

    // EN_O reflects the latched enable during APPLY itself; en_q holds it afterwards.
    assign EN_O    = (state == APPLY) ? lat_en : en_q;
    assign SEL_O   = sel_q;
    assign READY_O = (state == IDLE);
    assign BUSY_O  = ~READY_O;
    assign DONE_O  = (state == APPLY);

endmodule
